knight_sprite_addr_gen: RTL

//  Pixel-side address generator directly upstream of the knight sprite ROM/palette stage.

---
 rtl/knight_sprite_addr_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/knight_sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// knight_sprite_addr_gen
//
// Maps the current VGA scan position to an address in the knight sprite ROM.
// The address is taken relative to the knight's position latched at the start
// of the frame. It is mirrored when the knight faces left and offset by the
// current walk-cycle frame. The ROM holds NUM_FRAMES images of SPR_W x SPR_H
// pixels, stored back to back in row-major order.
//
// Pipeline: DrawX/DrawY -> rom_address takes 2 clocks.
//           DrawX/DrawY -> sprite_on takes 3 clocks, which lines it up with
//           the 1-cycle ROM read data.
//
// Optional build macro:
//   KNIGHT_SCALE2X_EN - draw the sprite at 2x size. The hit window doubles and
//                       the row/column indices use rel >> 1. The address range
//                       and the latency are the same as in the 1:1 build.
//
// Ports:
//   vga_clk      in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   DrawX/DrawY  in   current pixel column/row
//   vsync        in   VGA vsync, active-low; its falling edge is the frame event
//   knight_x/y   in   signed top-left corner of the sprite (11 bit)
//   facing_left  in   1 = mirror the sprite horizontally
//   walking      in   1 = advance the walk cycle, 0 = idle pose (frame 0)
//   rom_address  out  sprite ROM address (0 when the pixel misses the sprite)
//   sprite_on    out  pixel is inside the sprite, aligned with ROM data
//   anim_frame   out  current walk frame index
// -----------------------------------------------------------------------------
module knight_sprite_addr_gen #(
   parameter int SPR_W           = 30,
   parameter int SPR_H           = 64,
   parameter int NUM_FRAMES      = 4,
   parameter int TICKS_PER_FRAME = 6,
   parameter int ADDR_W          = 13
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              vsync,
   input  logic [10:0]       knight_x,
   input  logic [10:0]       knight_y,
   input  logic              facing_left,
   input  logic              walking,
   output logic [ADDR_W-1:0] rom_address,
   output logic              sprite_on,
   output logic [1:0]        anim_frame
);

`ifdef KNIGHT_SCALE2X_EN
   localparam int SCALE_SH = 1;
`else
   localparam int SCALE_SH = 0;
`endif

   localparam int HIT_W    = SPR_W << SCALE_SH;
   localparam int HIT_H    = SPR_H << SCALE_SH;
   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam int TICK_W   = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

   // Multiply by a constant as a sum of shifted copies of x, one for each set
   // bit of k. Results wrap at ADDR_W bits, which is the size of the ROM.
   function automatic logic [ADDR_W-1:0] mul_const(input logic [ADDR_W-1:0] x,
                                                   input logic [ADDR_W-1:0] k);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (k[i]) acc = acc + (x << i);
      end
      return acc;
   endfunction

   // ---------------------------------------------------------------- frame event
   logic              vsync_hist;
   logic              fev;
   logic [10:0]       sx, sy;
   logic              sface;
   logic [TICK_W-1:0] tick;
   logic [1:0]        frame;

   assign fev = vsync_hist & ~vsync;

   // Position and facing are sampled only at the frame event. The sprite
   // therefore cannot move partway down the screen, so no tearing is visible.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so that
         // every register samples values from before the clock edge.
         vsync_hist <= 1'b1;
         sx         <= '0;
         sy         <= '0;
         sface      <= 1'b0;
         tick       <= '0;
         frame      <= '0;
      end else begin
         vsync_hist <= vsync;
         if (fev) begin
            sx    <= knight_x;
            sy    <= knight_y;
            sface <= facing_left;
            if (!walking) begin
               tick  <= '0;
               frame <= '0;
            end else if (tick == TICK_W'(TICKS_PER_FRAME - 1)) begin
               tick  <= '0;
               frame <= (frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame + 2'd1;
            end else begin
               tick  <= tick + 1'b1;
            end
         end
      end
   end

   assign anim_frame = frame;

   // ---------------------------------------------------------------- stage 1
   // The 12-bit difference covers -1023..2047 and cannot overflow. Bit 11 is
   // the sign, so a set bit 11 means the pixel is left of or above the sprite.
   logic [11:0] rel_x_d, rel_y_d;
   logic        hit1_d;
   logic [11:0] rel_x, rel_y;
   logic        hit1;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      rel_x_d = {2'b00, DrawX} - {sx[10], sx};
      rel_y_d = {2'b00, DrawY} - {sy[10], sy};
      hit1_d  = !rel_x_d[11] && (rel_x_d < 12'(HIT_W)) &&
                !rel_y_d[11] && (rel_y_d < 12'(HIT_H));
   end

   // ---------------------------------------------------------------- stage 2
   logic [ADDR_W-1:0] col, row, addr_d;
   logic              hit2;

   always_comb begin
      row    = ADDR_W'(rel_y >> SCALE_SH);
      col    = ADDR_W'(rel_x >> SCALE_SH);
      if (sface) col = ADDR_W'(SPR_W - 1) - col;
      addr_d = mul_const(ADDR_W'(frame), ADDR_W'(FRAME_SZ)) +
               mul_const(row, ADDR_W'(SPR_W)) + col;
   end

   // ---------------------------------------------------------------- pipeline
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rel_x       <= '0;
         rel_y       <= '0;
         hit1        <= 1'b0;
         hit2        <= 1'b0;
         rom_address <= '0;
         sprite_on   <= 1'b0;
      end else begin
         rel_x       <= rel_x_d;
         rel_y       <= rel_y_d;
         hit1        <= hit1_d;
         hit2        <= hit1;
         rom_address <= hit1 ? addr_d : '0;
         sprite_on   <= hit2;
      end
   end

endmodule
